// File: rtl/pe_bist_pkg.sv
// Shared types and PE opcode constants for the PE built-in self-test controller.
package pe_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_NEXT,
    S_DONE
  } state_t;

  // Opcode field lives in instr[31:28]
  localparam logic [3:0] OP_MAC  = 4'h1;
  localparam logic [3:0] OP_ACT  = 4'h2;
  localparam logic [3:0] OP_NORM = 4'h3;
  localparam logic [3:0] OP_ATTN = 4'h5;

endpackage

// File: rtl/pe_bist_table.sv
// Test-vector register file: instruction, expected result and compare mask per entry.
module pe_bist_table #(
  parameter int unsigned NUM_TESTS  = 8,
  parameter int unsigned RES_WIDTH  = 128,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]           wr_instr,
  input  logic [RES_WIDTH-1:0]  wr_expect,
  input  logic [RES_WIDTH-1:0]  wr_mask,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rd_instr,
  output logic [RES_WIDTH-1:0]  rd_expect,
  output logic [RES_WIDTH-1:0]  rd_mask
);

  logic [31:0]          instr_mem  [NUM_TESTS];
  logic [RES_WIDTH-1:0] expect_mem [NUM_TESTS];
  logic [RES_WIDTH-1:0] mask_mem   [NUM_TESTS];

  // Contents are deliberately not reset; software loads the table before a run.
  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < NUM_TESTS)) begin
      instr_mem[waddr]  <= wr_instr;
      expect_mem[waddr] <= wr_expect;
      mask_mem[waddr]   <= wr_mask;
    end
  end

  assign rd_instr  = instr_mem[raddr];
  assign rd_expect = expect_mem[raddr];
  assign rd_mask   = mask_mem[raddr];

endmodule

// File: rtl/pe_bist_ctrl.sv
// Sequences table-driven tests through a PE: issue, await result (with timeout), compare, tally.
module pe_bist_ctrl
  import pe_bist_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned VECTOR_WIDTH   = 4,
  parameter int unsigned NUM_TESTS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            start,
  input  logic                                            abort,
  input  logic [$clog2(NUM_TESTS+1)-1:0]                  cfg_num_tests,
  input  logic                                            tbl_we,
  input  logic [((NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1)-1:0] tbl_addr,
  input  logic [31:0]                                     tbl_instr,
  input  logic [DATA_WIDTH*VECTOR_WIDTH-1:0]              tbl_expect,
  input  logic [DATA_WIDTH*VECTOR_WIDTH-1:0]              tbl_cmp_mask,
  output logic                                            pe_valid_o,
  output logic [31:0]                                     pe_instr_o,
  input  logic                                            pe_ready_i,
  input  logic                                            pe_valid_i,
  input  logic [DATA_WIDTH*VECTOR_WIDTH-1:0]              pe_result_i,
  output logic                                            busy,
  output logic                                            done,
  output logic                                            all_pass,
  output logic [$clog2(NUM_TESTS+1)-1:0]                  pass_cnt,
  output logic [$clog2(NUM_TESTS+1)-1:0]                  fail_cnt,
  output logic [$clog2(NUM_TESTS+1)-1:0]                  timeout_cnt,
  output logic [((NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1)-1:0] first_fail_idx,
  output logic                                            first_fail_vld
);

  localparam int unsigned RW = DATA_WIDTH * VECTOR_WIDTH;
  localparam int unsigned CW = $clog2(NUM_TESTS + 1);
  localparam int unsigned AW = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] MAX_TESTS = CW'(NUM_TESTS);
  localparam logic [TW-1:0] TMR_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_t         state, state_n;
  logic [AW-1:0]  idx;
  logic [TW-1:0]  timer;
  logic [CW-1:0]  num_lat, cfg_clamped;
  logic [RW-1:0]  result_q;
  logic [31:0]    rd_instr;
  logic [RW-1:0]  rd_expect, rd_mask;
  logic           mismatch, last;
  logic           run_clr, cap, tmr_clr, tmr_inc, idx_inc, pass_inc, fail_inc, to_inc;

  pe_bist_table #(
    .NUM_TESTS  (NUM_TESTS),
    .RES_WIDTH  (RW),
    .ADDR_WIDTH (AW)
  ) u_table (
    .clk       (clk),
    .we        (tbl_we && !busy),
    .waddr     (tbl_addr),
    .wr_instr  (tbl_instr),
    .wr_expect (tbl_expect),
    .wr_mask   (tbl_cmp_mask),
    .raddr     (idx),
    .rd_instr  (rd_instr),
    .rd_expect (rd_expect),
    .rd_mask   (rd_mask)
  );

  assign cfg_clamped = (cfg_num_tests > MAX_TESTS) ? MAX_TESTS : cfg_num_tests;
  assign mismatch    = |((result_q ^ rd_expect) & rd_mask);
  assign last        = ((CW'(idx) + 1'b1) == num_lat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    run_clr    = 1'b0;
    cap        = 1'b0;
    tmr_clr    = 1'b0;
    tmr_inc    = 1'b0;
    idx_inc    = 1'b0;
    pass_inc   = 1'b0;
    fail_inc   = 1'b0;
    to_inc     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    pe_valid_o = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (start) begin
          run_clr = 1'b1;
          state_n = (cfg_clamped == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy       = 1'b1;
        pe_valid_o = 1'b1;
        if (pe_ready_i) begin
          tmr_clr = 1'b1;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (pe_valid_i) begin
          cap     = 1'b1;
          state_n = S_CHECK;
        end else if (timer == TMR_LAST) begin
          fail_inc = 1'b1;
          to_inc   = 1'b1;
          state_n  = S_NEXT;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      S_CHECK: begin
        busy     = 1'b1;
        pass_inc = !mismatch;
        fail_inc = mismatch;
        state_n  = S_NEXT;
      end
      S_NEXT: begin
        busy = 1'b1;
        if (last) begin
          state_n = S_DONE;
        end else begin
          idx_inc = 1'b1;
          state_n = S_ISSUE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Abort overrides every transition and suppresses all bookkeeping this cycle
    if (abort) begin
      state_n  = S_IDLE;
      run_clr  = 1'b0;
      cap      = 1'b0;
      tmr_clr  = 1'b0;
      tmr_inc  = 1'b0;
      idx_inc  = 1'b0;
      pass_inc = 1'b0;
      fail_inc = 1'b0;
      to_inc   = 1'b0;
    end
  end

  assign pe_instr_o = pe_valid_o ? rd_instr : '0;
  assign all_pass   = done && (fail_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx            <= '0;
      timer          <= '0;
      num_lat        <= '0;
      result_q       <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      timeout_cnt    <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      if (run_clr) begin
        idx            <= '0;
        num_lat        <= cfg_clamped;
        pass_cnt       <= '0;
        fail_cnt       <= '0;
        timeout_cnt    <= '0;
        first_fail_idx <= '0;
        first_fail_vld <= 1'b0;
      end
      if (tmr_clr)      timer <= '0;
      else if (tmr_inc) timer <= timer + 1'b1;
      if (cap)     result_q <= pe_result_i;
      if (idx_inc) idx <= idx + 1'b1;
      if (pass_inc && (pass_cnt != '1)) pass_cnt <= pass_cnt + 1'b1;
      if (to_inc && (timeout_cnt != '1)) timeout_cnt <= timeout_cnt + 1'b1;
      if (fail_inc) begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        if (!first_fail_vld) begin
          first_fail_vld <= 1'b1;
          first_fail_idx <= idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_bist_ctrl.sv
// Directed self-checking bench for pe_bist_ctrl with a small behavioural PE responder.
module tb_pe_bist_ctrl;
  import pe_bist_pkg::*;

  localparam int unsigned RW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [3:0]    cfg_num_tests = '0;
  logic          tbl_we = 1'b0;
  logic [2:0]    tbl_addr = '0;
  logic [31:0]   tbl_instr = '0;
  logic [RW-1:0] tbl_expect = '0;
  logic [RW-1:0] tbl_cmp_mask = '0;
  logic          pe_valid_o;
  logic [31:0]   pe_instr_o;
  logic          pe_ready_i = 1'b0;
  logic          pe_valid_i = 1'b0;
  logic [RW-1:0] pe_result_i = '0;
  logic          busy, done, all_pass, first_fail_vld;
  logic [3:0]    pass_cnt, fail_cnt, timeout_cnt;
  logic [2:0]    first_fail_idx;

  int checks = 0;
  int errors = 0;

  logic [31:0]   instr_tab [16];
  logic [RW-1:0] exp_tab   [16];
  logic [RW-1:0] resp_xor  [16];
  int            mute_idx = -1;
  int            cyc = 0;
  int            hs_total = 0;
  int            hs_edge   [16];
  int            issue_cyc [16];
  logic          prev_valid = 1'b0;
  logic          m_hs;
  int            m_idx;
  int            hs0;

  pe_bist_ctrl #(
    .DATA_WIDTH     (32),
    .VECTOR_WIDTH   (4),
    .NUM_TESTS      (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .cfg_num_tests  (cfg_num_tests),
    .tbl_we         (tbl_we),
    .tbl_addr       (tbl_addr),
    .tbl_instr      (tbl_instr),
    .tbl_expect     (tbl_expect),
    .tbl_cmp_mask   (tbl_cmp_mask),
    .pe_valid_o     (pe_valid_o),
    .pe_instr_o     (pe_instr_o),
    .pe_ready_i     (pe_ready_i),
    .pe_valid_i     (pe_valid_i),
    .pe_result_i    (pe_result_i),
    .busy           (busy),
    .done           (done),
    .all_pass       (all_pass),
    .pass_cnt       (pass_cnt),
    .fail_cnt       (fail_cnt),
    .timeout_cnt    (timeout_cnt),
    .first_fail_idx (first_fail_idx),
    .first_fail_vld (first_fail_vld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // PE responder: sees the handshake before the edge, answers for one cycle after it.
  always begin
    @(negedge clk);
    m_hs  = rst_n && !abort && pe_valid_o && pe_ready_i;
    m_idx = int'(pe_instr_o[3:0]);
    if (pe_valid_o && !prev_valid) issue_cyc[m_idx] = cyc;
    prev_valid = pe_valid_o;
    if (m_hs) begin
      hs_total++;
      hs_edge[m_idx] = cyc + 1;
    end
    @(posedge clk);
    #1;
    if (m_hs && (m_idx != mute_idx)) begin
      pe_valid_i  = 1'b1;
      pe_result_i = exp_tab[m_idx] ^ resp_xor[m_idx];
    end else begin
      pe_valid_i  = 1'b0;
      pe_result_i = '0;
    end
  end

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] ins, input logic [RW-1:0] e, input logic [RW-1:0] m);
    tbl_we       = 1'b1;
    tbl_addr     = 3'(a);
    tbl_instr    = ins;
    tbl_expect   = e;
    tbl_cmp_mask = m;
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((done !== 1'b1) && (n < 200)) begin
      tick();
      n++;
    end
    chk(tag, RW'(done), RW'(1));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      instr_tab[i] = '0;
      exp_tab[i]   = '0;
      resp_xor[i]  = '0;
    end
    instr_tab[0] = {OP_MAC,  24'h0, 4'h0};
    instr_tab[1] = {OP_ACT,  24'h0, 4'h1};
    instr_tab[2] = {OP_NORM, 24'h0, 4'h2};
    instr_tab[3] = {OP_ATTN, 24'h0, 4'h3};
    for (int i = 0; i < 4; i++)
      exp_tab[i] = {32'hDEAD_0000 + 32'(i), 32'hBEEF_0000 + 32'(i),
                    32'hCAFE_0000 + 32'(i), 32'hF00D_0000 + 32'(i)};

    // Reset state
    tick();
    tick();
    chk("rst_busy", RW'(busy), RW'(0));
    chk("rst_done", RW'(done), RW'(0));
    chk("rst_all_pass", RW'(all_pass), RW'(0));
    chk("rst_valid", RW'(pe_valid_o), RW'(0));
    chk("rst_instr", RW'(pe_instr_o), RW'(0));
    chk("rst_pass_cnt", RW'(pass_cnt), RW'(0));
    chk("rst_ffv", RW'(first_fail_vld), RW'(0));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) wr(i, instr_tab[i], exp_tab[i], '1);

    // All four opcodes pass
    cfg_num_tests = 4'd4;
    pe_ready_i    = 1'b1;
    hs0           = hs_total;
    pulse_start();
    chk("A_busy", RW'(busy), RW'(1));
    chk("A_valid", RW'(pe_valid_o), RW'(1));
    chk("A_instr0", RW'(pe_instr_o), RW'(instr_tab[0]));
    wait_done("A_done");
    chk("A_pass_cnt", RW'(pass_cnt), RW'(4));
    chk("A_fail_cnt", RW'(fail_cnt), RW'(0));
    chk("A_timeout_cnt", RW'(timeout_cnt), RW'(0));
    chk("A_all_pass", RW'(all_pass), RW'(1));
    chk("A_ffv", RW'(first_fail_vld), RW'(0));
    chk("A_handshakes", RW'(hs_total - hs0), RW'(4));
    chk("A_busy_end", RW'(busy), RW'(0));

    // Lane0 corrupted but masked off; busy-time table write and start are ignored
    wr(2, instr_tab[2], exp_tab[2], {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h0});
    resp_xor[2] = 128'h0000_00FF;
    hs0 = hs_total;
    pulse_start();
    tick();
    tick();
    tbl_we     = 1'b1;
    tbl_addr   = 3'd3;
    tbl_instr  = '0;
    tbl_expect = '0;
    start      = 1'b1;
    tick();
    tbl_we = 1'b0;
    start  = 1'b0;
    wait_done("B1_done");
    chk("B1_pass_cnt", RW'(pass_cnt), RW'(4));
    chk("B1_fail_cnt", RW'(fail_cnt), RW'(0));
    chk("B1_all_pass", RW'(all_pass), RW'(1));
    chk("B1_handshakes", RW'(hs_total - hs0), RW'(4));

    // Same corruption, lane0 now compared
    wr(2, instr_tab[2], exp_tab[2], '1);
    pulse_start();
    wait_done("B2_done");
    chk("B2_pass_cnt", RW'(pass_cnt), RW'(3));
    chk("B2_fail_cnt", RW'(fail_cnt), RW'(1));
    chk("B2_timeout_cnt", RW'(timeout_cnt), RW'(0));
    chk("B2_ffi", RW'(first_fail_idx), RW'(2));
    chk("B2_ffv", RW'(first_fail_vld), RW'(1));
    chk("B2_all_pass", RW'(all_pass), RW'(0));

    // Entry 1 never answers
    resp_xor[2] = '0;
    mute_idx    = 1;
    pulse_start();
    wait_done("C_done");
    chk("C_pass_cnt", RW'(pass_cnt), RW'(3));
    chk("C_fail_cnt", RW'(fail_cnt), RW'(1));
    chk("C_timeout_cnt", RW'(timeout_cnt), RW'(1));
    chk("C_ffi", RW'(first_fail_idx), RW'(1));
    chk("C_all_pass", RW'(all_pass), RW'(0));
    chk("C_issue_gap", RW'(issue_cyc[2] - hs_edge[1]), RW'(17));

    // Backpressure: request held stable while ready is low
    mute_idx      = -1;
    cfg_num_tests = 4'd1;
    pe_ready_i    = 1'b0;
    hs0           = hs_total;
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      chk("D_valid_hold", RW'(pe_valid_o), RW'(1));
      chk("D_instr_hold", RW'(pe_instr_o), RW'(instr_tab[0]));
      tick();
    end
    pe_ready_i = 1'b1;
    chk("D_valid_before_hs", RW'(pe_valid_o), RW'(1));
    tick();
    wait_done("D_done");
    chk("D_handshakes", RW'(hs_total - hs0), RW'(1));
    chk("D_pass_cnt", RW'(pass_cnt), RW'(1));
    chk("D_all_pass", RW'(all_pass), RW'(1));

    // Abort during entry-1 WAIT with a simultaneous start
    mute_idx      = 1;
    cfg_num_tests = 4'd4;
    pulse_start();
    repeat (6) tick();
    chk("E_busy_wait", RW'(busy), RW'(1));
    chk("E_valid_wait", RW'(pe_valid_o), RW'(0));
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("E_busy_abort", RW'(busy), RW'(0));
    chk("E_done_abort", RW'(done), RW'(0));
    chk("E_pass_hold", RW'(pass_cnt), RW'(1));
    chk("E_fail_hold", RW'(fail_cnt), RW'(0));
    tick();
    chk("E_still_idle", RW'(busy), RW'(0));
    cfg_num_tests = 4'd0;
    pulse_start();
    chk("E_zero_done", RW'(done), RW'(1));
    chk("E_zero_all_pass", RW'(all_pass), RW'(1));
    chk("E_zero_busy", RW'(busy), RW'(0));
    chk("E_zero_pass_cnt", RW'(pass_cnt), RW'(0));

    // Asynchronous reset in the middle of a run
    mute_idx      = -1;
    cfg_num_tests = 4'd4;
    pulse_start();
    repeat (4) tick();
    chk("F_valid_pre", RW'(pe_valid_o), RW'(1));
    chk("F_pass_pre", RW'(pass_cnt), RW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("F_valid_async", RW'(pe_valid_o), RW'(0));
    chk("F_instr_async", RW'(pe_instr_o), RW'(0));
    chk("F_busy_async", RW'(busy), RW'(0));
    chk("F_pass_async", RW'(pass_cnt), RW'(0));
    tick();
    rst_n = 1'b1;
    tick();
    chk("F_busy_after", RW'(busy), RW'(0));
    chk("F_done_after", RW'(done), RW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_bist_ctrl.md
PE_BIST_CTRL -- requirements
Module: pe_bist_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bits per vector lane.
REQ-002 SHALL have parameter VECTOR_WIDTH, default 4, lanes per packed result.
REQ-003 SHALL have parameter NUM_TESTS, default 8, test-table depth (>=1).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum WAIT cycles per test (>=2).
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-006 SHALL have: start input 1, begin run; abort input 1, cancel run; cfg_num_tests input $clog2(NUM_TESTS+1), tests to run.
REQ-007 SHALL have table port: tbl_we input 1; tbl_addr input $clog2(NUM_TESTS); tbl_instr input 32; tbl_expect input DATA_WIDTH*VECTOR_WIDTH; tbl_cmp_mask input DATA_WIDTH*VECTOR_WIDTH, bit=1 compared.
REQ-008 SHALL have PE port: pe_valid_o output 1; pe_instr_o output 32; pe_ready_i input 1; pe_valid_i input 1; pe_result_i input DATA_WIDTH*VECTOR_WIDTH.
REQ-009 SHALL have status: busy output 1; done output 1; all_pass output 1; pass_cnt, fail_cnt, timeout_cnt outputs $clog2(NUM_TESTS+1) each; first_fail_idx output $clog2(NUM_TESTS); first_fail_vld output 1.

Function
REQ-010 SHALL implement states IDLE, ISSUE, WAIT, CHECK, NEXT, DONE; busy=1 in ISSUE/WAIT/CHECK/NEXT.
REQ-011 IDLE/DONE + start: clear counters, first_fail_vld, done, idx=0; latch cfg_num_tests (clamped to NUM_TESTS); go ISSUE next cycle, or DONE if latched value is 0 (all_pass=1).
REQ-012 ISSUE: pe_valid_o=1, pe_instr_o=table[idx], held stable until pe_ready_i sampled 1; then WAIT, timer=0.
REQ-013 WAIT: if pe_valid_i=1, capture pe_result_i, go CHECK; else timer++; when timer reaches TIMEOUT_CYCLES-1 without pe_valid_i, fail_cnt++, timeout_cnt++, record failure, go NEXT.
REQ-014 pe_valid_i outside WAIT SHALL be ignored.
REQ-015 CHECK (one cycle): pass iff ((captured ^ expect) & cmp_mask)==0; pass -> pass_cnt++; fail -> fail_cnt++, record failure; go NEXT.
REQ-016 Record failure: if first_fail_vld=0, first_fail_idx=idx, first_fail_vld=1; later failures do not overwrite.
REQ-017 NEXT: idx==latched_num-1 -> DONE; else idx++, ISSUE.
REQ-018 DONE: done=1 and all_pass=(fail_cnt==0), held until next start or abort.
REQ-019 abort=1 in any state -> IDLE next cycle, pe_valid_o=0, done=0, counters hold; abort wins over simultaneous start.
REQ-020 start while busy SHALL be ignored.
REQ-021 tbl_we while busy SHALL be ignored; otherwise writes all three fields at tbl_addr in one cycle; out-of-range tbl_addr ignored.
REQ-022 pe_instr_o SHALL be 0 whenever pe_valid_o=0.
REQ-023 Counters SHALL saturate at all-ones.

Reset
REQ-024 rst_n low SHALL force IDLE, all outputs 0, idx/timer/counters 0; table contents undefined, not reset.
REQ-025 Reset mid-run SHALL drop pe_valid_o asynchronously; no partial result retained.

Structure
REQ-026 Package pe_bist_pkg SHALL hold the state enum and PE opcode constants MAC=4'h1, ACT=4'h2, NORM=4'h3, ATTN=4'h5 (instr[31:28]).
REQ-027 Sub-module pe_bist_table SHALL hold the NUM_TESTS x (32+2*DATA_WIDTH*VECTOR_WIDTH) register file, one write port, one combinational read port.

Verification
REQ-028 Four entries MAC/ACT/NORM/ATTN, PE model ready=1, result=expect one cycle after handshake, cfg=4 -> pass_cnt=4, fail_cnt=0, done=1, all_pass=1, 4 ISSUE-to-WAIT handshakes.
REQ-029 Entry 2 result lane0 differs, cmp_mask lane0=0 -> pass; mask lane0 all-ones -> fail_cnt=1, first_fail_idx=2, all_pass=0.
REQ-030 PE never asserts pe_valid_i on entry 1, TIMEOUT_CYCLES=16 -> timeout_cnt=1, fail_cnt=1, entry 2 issued exactly 17 cycles after entry-1 handshake.
REQ-031 pe_ready_i low 5 cycles in ISSUE -> pe_valid_o and pe_instr_o stable all 5 cycles; single handshake counted.
REQ-032 abort during WAIT of entry 1 with simultaneous start -> IDLE next cycle, busy=0, done=0; later start with cfg=0 -> DONE next cycle, all_pass=1.
